// File: rtl/halfword_serializer.sv
// rtl/halfword_serializer.sv - narrows 32-bit words (or single halfwords) into 16-bit beats
module halfword_serializer #(
  parameter bit HI_FIRST = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_half,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] data;
  logic [31:0] data_nxt;
  logic        half;
  logic        half_nxt;
  logic        in_xfer;
  logic        out_xfer;

  // Outputs come only from registered state, so out_valid never sees out_ready.
  assign out_valid = (state != IDLE);
  assign busy      = (state != IDLE);
  assign out_last  = (state == SECOND) || ((state == FIRST) && half);
  assign in_ready  = (state == IDLE) || (out_valid && out_ready && out_last);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  always_comb begin
    out_data = 16'h0000;
    case (state)
      FIRST: begin
        if (half || !HI_FIRST) out_data = data[15:0];
        else                   out_data = data[31:16];
      end
      SECOND: begin
        if (HI_FIRST) out_data = data[15:0];
        else          out_data = data[31:16];
      end
      default: out_data = 16'h0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data;
    half_nxt  = half;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          state_nxt = FIRST;
          data_nxt  = in_data;
          half_nxt  = in_half;
        end
      end
      FIRST, SECOND: begin
        if (out_xfer) begin
          if ((state == FIRST) && !half) begin
            state_nxt = SECOND;
          end else if (in_xfer) begin
            // Final beat leaving while the next word arrives: reload without a bubble.
            state_nxt = FIRST;
            data_nxt  = in_data;
            half_nxt  = in_half;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      data  <= 32'h0;
      half  <= 1'b0;
    end else begin
      state <= state_nxt;
      data  <= data_nxt;
      half  <= half_nxt;
    end
  end

endmodule

// File: doc/halfword_serializer.md
HALFWORD_SERIALIZER -- requirements
Module: halfword_serializer

Interface
REQ-001 The block SHALL have parameter HI_FIRST, default 0; 0 = low half sent first, 1 = high half sent first.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1, upstream word present.
REQ-005 The block SHALL have port in_ready, output, 1, word accepted this cycle when in_valid is also 1.
REQ-006 The block SHALL have port in_data, input, 32, word to narrow.
REQ-007 The block SHALL have port in_half, input, 1, where 1 means send only in_data[15:0] as a single beat (halfword store).
REQ-008 The block SHALL have port out_valid, output, 1, a beat is presented.
REQ-009 The block SHALL have port out_ready, input, 1, downstream takes the beat when out_valid is also 1.
REQ-010 The block SHALL have port out_data, output, 16, beat payload.
REQ-011 The block SHALL have port out_last, output, 1, marking the final beat of the current word.
REQ-012 The block SHALL have port busy, output, 1, which is 1 whenever state is not IDLE.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, FIRST and SECOND, with a 32-bit data register and a 1-bit half register.
REQ-014 A transfer SHALL occur on a cycle where valid and ready are both 1; a transfer SHALL be the only event that changes data or state.
REQ-015 In IDLE, the block SHALL drive in_ready=1 and out_valid=0.
REQ-016 On an IDLE input transfer, the block SHALL capture in_data and in_half and go to FIRST; first beat latency SHALL be 1 cycle.
REQ-017 In FIRST, the block SHALL drive out_valid=1.
REQ-018 In FIRST, out_data SHALL be data[15:0] when half=1; otherwise it SHALL be data[15:0] if HI_FIRST=0 and data[31:16] if HI_FIRST=1.
REQ-019 In FIRST, out_last SHALL equal half.
REQ-020 In SECOND, the block SHALL drive out_valid=1, out_last=1, and out_data set to the half not sent in FIRST.
REQ-021 When FIRST sees an output transfer with half=0, the block SHALL go to SECOND.
REQ-022 When FIRST sees an output transfer with half=1, or SECOND sees an output transfer, the block SHALL go to IDLE unless a concurrent input transfer occurs.
REQ-023 in_ready SHALL equal (state==IDLE) OR (out_valid AND out_ready AND out_last), which is combinational.
REQ-024 On a final-beat output transfer with a concurrent input transfer, the block SHALL capture the new word and go to FIRST with no bubble; full words SHALL sustain 1 beat/cycle.
REQ-025 While out_valid=1 and out_ready=0, out_data and out_last SHALL stay stable and state SHALL hold indefinitely.
REQ-026 in_data and in_half SHALL be ignored when no input transfer occurs.
REQ-027 When half=1, data[31:16] SHALL never be emitted.
REQ-028 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-029 Asserting rst_n=0 SHALL asynchronously force state=IDLE, data=0, half=0, out_valid=0, out_last=0, out_data=0, busy=0; in_ready SHALL then be 1.
REQ-030 Reset asserted mid-word SHALL discard the word; no remaining beat SHALL appear after release.
REQ-031 After rst_n deasserts, the first input transfer SHALL be accepted on the first rising edge with in_valid=1.

Verification
REQ-032 HI_FIRST=0, in_data=0x1234ABCD, in_half=0, out_ready=1 -> beats 0xABCD (last=0) then 0x1234 (last=1) on consecutive cycles.
REQ-033 HI_FIRST=1, same word -> beats 0x1234 then 0xABCD; in_half=1 with 0xFFFF5A5A -> single beat 0x5A5A, last=1.
REQ-034 Back-to-back 0x11112222 and 0x33334444 with in_valid and out_ready held 1 -> 0x2222, 0x1111, 0x4444, 0x3333 on four consecutive cycles; in_ready=1 on cycles 0 and 2.
REQ-035 out_ready=0 for 5 cycles during SECOND -> out_data held at the high half, in_ready=0 throughout, and the beat is delivered once after out_ready rises.
REQ-036 rst_n pulsed low during SECOND of 0xDEADBEEF -> out_valid=0 at once; after release, the next word 0x00010002 gives 0x0002 then 0x0001 with no 0xDEAD beat.
